// File: rtl/cpu_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package cpu_pkg;
    typedef enum logic [1:0] {FETCH, EXEC1, EXEC2, HALTED} cpu_state_t;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR_DEF    = 32'h0000_0000;
endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Instruction memory read bus with waitrequest stalling.
interface instr_fetch_ctrl_if;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [31:0] address;
    logic        read;

    modport master (output address, read, input waitrequest, readdata);
    modport slave  (input address, read, output waitrequest, readdata);
endinterface

// File: rtl/instr_fetch_ctrl_pc_next.sv
// Next-PC selection: sequential step or delay-slot redirect, with halt detection.
module pc_next
    import cpu_pkg::*;
#(
    parameter logic [31:0] HALT_ADDR = HALT_ADDR_DEF
) (
    input  logic [31:0] pc,
    input  logic        delay_pending,
    input  logic [31:0] redirect,
    output logic [31:0] next_pc,
    output logic        halt_now
);
    // pc + 4 wraps modulo 2^32; low bits are passed through untouched
    assign next_pc  = delay_pending ? redirect : pc + 32'd4;
    assign halt_now = delay_pending && (redirect == HALT_ADDR);
endmodule

// File: rtl/instr_fetch_ctrl.sv
// FETCH -> EXEC1 -> EXEC2 sequencer owning the PC, branch delay slot and halt.
module instr_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    instr_fetch_ctrl_if.master        mem,
    output logic                      fetch,
    output logic                      exec1,
    output logic                      exec2,
    output logic [31:0]               current_instruction,
    output logic [31:0]               pc_exec,
    input  logic                      branch_taken,
    input  logic [31:0]               branch_target,
    input  logic                      stall_req,
    output logic                      active
);
    cpu_state_t  state;
    logic [31:0] pc;
    logic [31:0] redirect;
    logic        delay_pending;
    logic [31:0] next_pc;
    logic        halt_now;

    pc_next #(.HALT_ADDR(HALT_ADDR)) u_pc_next (
        .pc            (pc),
        .delay_pending (delay_pending),
        .redirect      (redirect),
        .next_pc       (next_pc),
        .halt_now      (halt_now)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= FETCH;
            pc                  <= RESET_VECTOR;
            current_instruction <= '0;
            pc_exec             <= '0;
            delay_pending       <= 1'b0;
            redirect            <= '0;
            active              <= 1'b0;
        end else if (!active) begin
            // idle cycle after reset; HALTED never wakes up again
            if (state != HALTED) active <= 1'b1;
        end else begin
            case (state)
                FETCH: if (!mem.waitrequest) begin
                    current_instruction <= mem.readdata;
                    pc_exec             <= pc;
                    state               <= EXEC1;
                end
                EXEC1: state <= EXEC2;
                EXEC2: if (!stall_req) begin
                    if (delay_pending) begin
                        // end of delay slot: take the captured redirect
                        delay_pending <= 1'b0;
                        if (halt_now) begin
                            state  <= HALTED;
                            active <= 1'b0;
                        end else begin
                            pc    <= next_pc;
                            state <= FETCH;
                        end
                    end else begin
                        if (branch_taken) begin
                            redirect      <= branch_target;
                            delay_pending <= 1'b1;
                        end
                        pc    <= next_pc;
                        state <= FETCH;
                    end
                end
                default: active <= 1'b0;
            endcase
        end
    end

    assign fetch       = active && (state == FETCH);
    assign exec1       = active && (state == EXEC1);
    assign exec2       = active && (state == EXEC2);
    assign mem.read    = fetch;
    assign mem.address = fetch ? pc : '0;
endmodule
